// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - iterative AES InvMixColumns engine, COLS_PER_CYCLE columns per clock
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadCols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT        state;
    stateT        nextState;
    logic [1:0]   cnt;
    logic [2:0]   cntSum;
    logic         lastStep;
    logic [127:0] inReg;
    logic [127:0] outReg;
    logic [127:0] nextOut;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // All four coefficient products come from one x2/x4/x8 chain per byte.
    function automatic logic [31:0] invMixCol(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[8*(3-r) +: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [6:0] colBase(input logic [1:0] c, input int k);
        logic [1:0] idx;
        idx = c + 2'(k);
        return {idx, 5'b0};
    endfunction

    assign cntSum   = {1'b0, cnt} + 3'(COLS_PER_CYCLE);
    assign lastStep = cntSum[2];

    always_comb begin
        nextOut = outReg;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            nextOut[colBase(cnt, k) +: 32] = invMixCol(inReg[colBase(cnt, k) +: 32]);
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (lastStep) nextState = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            inReg  <= 128'h0;
            outReg <= 128'h0;
        end else begin
            state <= nextState;
            if (state == IDLE && in_valid) begin
                inReg <= in_data;
                cnt   <= 2'd0;
            end
            if (state == BUSY) begin
                outReg <= nextOut;
                cnt    <= cntSum[1:0];
            end
        end
    end

    assign out_data = outReg;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb/tb_inv_mix_columns_iter.sv - bench for inv_mix_columns_iter at 1, 2 and 4 columns per cycle
module tb_inv_mix_columns_iter;

    localparam int ND = 3;

    logic         clk = 1'b0;
    logic         rst [ND];
    logic         inValid [ND];
    logic [127:0] inData [ND];
    logic         outReady [ND];
    logic         inReady [ND];
    logic         outValid [ND];
    logic         busy [ND];
    logic [127:0] outData [ND];

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : gDut
        inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk      (clk),
            .rst      (rst[g]),
            .in_valid (inValid[g]),
            .in_ready (inReady[g]),
            .in_data  (inData[g]),
            .out_valid(outValid[g]),
            .out_ready(outReady[g]),
            .out_data (outData[g]),
            .busy     (busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mixState(input logic [127:0] s, input bit inv);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef[(k - row + 4) % 4], s[32*c + 24 - 8*k +: 8]);
                r[32*c + 24 - 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBlock(input int d, input logic [127:0] data, output int lat);
        int w;
        w = 0;
        while (!inReady[d] && w < 20) begin
            step();
            w++;
        end
        inValid[d] = 1'b1;
        inData[d]  = data;
        step();
        inValid[d] = 1'b0;
        inData[d]  = rand128();
        lat = 0;
        do begin
            step();
            lat++;
        end while (!outValid[d] && lat < 20);
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; inValid[d] = 1'b1; inData[d] = rand128(); outReady[d] = 1'b0;
        end
        step();
        step();
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b0; inValid[d] = 1'b0;
        end
        for (int d = 0; d < ND; d++) begin
            nCompared++;
            if ({inReady[d], outValid[d], busy[d]} !== 3'b100 || outData[d] !== 128'h0) begin
                nMismatched++;
                $display("FAIL reset d=%0d got rdy/vld/busy=%b%b%b data=%h want 100 data=0",
                         d, inReady[d], outValid[d], busy[d], outData[d]);
            end
        end
    endtask

    task automatic test_vectors(input int d);
        logic [127:0] vin [7];
        logic [127:0] vexp [7];
        int lat;
        vin[0] = 128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc; vexp[0] = 128'hdb135345_db135345_db135345_db135345;
        vin[1] = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8; vexp[1] = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        vin[2] = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101; vexp[2] = vin[2];
        for (int i = 3; i < 7; i++) begin
            vin[i]  = rand128();
            vexp[i] = mixState(vin[i], 1'b1);
        end
        for (int i = 0; i < 7; i++) begin
            sendBlock(d, vin[i], lat);
            nCompared++;
            if (lat != (4 >> d)) begin
                nMismatched++;
                $display("FAIL latency d=%0d vec=%0d got %0d want %0d", d, i, lat, 4 >> d);
            end
            nCompared++;
            if (outData[d] !== vexp[i] || outData[d] !== mixState(vin[i], 1'b1)) begin
                nMismatched++;
                $display("FAIL vector d=%0d vec=%0d got %h want %h", d, i, outData[d], vexp[i]);
            end
            outReady[d] = 1'b1;
            step();
            outReady[d] = 1'b0;
            nCompared++;
            if (outValid[d] !== 1'b0 || inReady[d] !== 1'b1) begin
                nMismatched++;
                $display("FAIL release d=%0d got vld=%b rdy=%b want vld=0 rdy=1", d, outValid[d], inReady[d]);
            end
        end
    endtask

    task automatic test_backpressure(input int d);
        logic [127:0] orig, hold;
        int lat;
        orig = rand128();
        sendBlock(d, mixState(orig, 1'b0), lat);
        hold = outData[d];
        for (int i = 0; i < 10; i++) begin
            nCompared++;
            if (outValid[d] !== 1'b1 || inReady[d] !== 1'b0 || outData[d] !== hold || hold !== orig) begin
                nMismatched++;
                $display("FAIL backpressure d=%0d cyc=%0d got vld=%b rdy=%b data=%h want vld=1 rdy=0 data=%h",
                         d, i, outValid[d], inReady[d], outData[d], orig);
            end
            inValid[d] = 1'($urandom_range(0, 1));
            inData[d]  = rand128();
            step();
        end
        inValid[d]  = 1'b0;
        outReady[d] = 1'b1;
        step();
        outReady[d] = 1'b0;
        nCompared++;
        if (inReady[d] !== 1'b1 || outValid[d] !== 1'b0 || busy[d] !== 1'b0) begin
            nMismatched++;
            $display("FAIL bp_release d=%0d got rdy=%b vld=%b busy=%b want 1 0 0",
                     d, inReady[d], outValid[d], busy[d]);
        end
    endtask

    task automatic test_reset_midop(input int d);
        logic [127:0] orig;
        int lat;
        inValid[d] = 1'b1;
        inData[d]  = rand128();
        step();
        inValid[d] = 1'b0;
        step();
        rst[d] = 1'b1;
        step();
        rst[d] = 1'b0;
        nCompared++;
        if (outValid[d] !== 1'b0 || inReady[d] !== 1'b1 || outData[d] !== 128'h0) begin
            nMismatched++;
            $display("FAIL midop_reset d=%0d got vld=%b rdy=%b data=%h want 0 1 0",
                     d, outValid[d], inReady[d], outData[d]);
        end
        orig = rand128();
        sendBlock(d, mixState(orig, 1'b0), lat);
        nCompared++;
        if (lat != (4 >> d) || outData[d] !== orig) begin
            nMismatched++;
            $display("FAIL after_reset d=%0d got lat=%0d data=%h want lat=%0d data=%h",
                     d, lat, outData[d], 4 >> d, orig);
        end
        outReady[d] = 1'b1;
        step();
        outReady[d] = 1'b0;
    endtask

    task automatic test_back_to_back(input int d, input int n);
        logic [127:0] expQ [$];
        logic [127:0] pendOrig, got, want;
        bit havePend, accepted, consumed;
        int sent, received, cyc;
        sent = 0; received = 0; cyc = 0; havePend = 1'b0;
        while (received < n && cyc < 40 * n) begin
            if (!havePend && sent < n) begin
                pendOrig = rand128();
                havePend = 1'b1;
            end
            inValid[d]  = havePend && ($urandom_range(0, 3) != 0);
            inData[d]   = inValid[d] ? mixState(pendOrig, 1'b0) : rand128();
            outReady[d] = ($urandom_range(0, 2) != 0);
            accepted = inValid[d] && inReady[d];
            consumed = outValid[d] && outReady[d];
            got      = outData[d];
            step();
            cyc++;
            if (accepted) begin
                expQ.push_back(pendOrig);
                sent++;
                havePend = 1'b0;
            end
            if (consumed) begin
                received++;
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("FAIL roundtrip_extra d=%0d got %h want no output", d, got);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) begin
                        nMismatched++;
                        $display("FAIL roundtrip d=%0d blk=%0d got %h want %h", d, received - 1, got, want);
                    end
                end
            end
        end
        inValid[d]  = 1'b0;
        outReady[d] = 1'b0;
        nCompared++;
        if (received != n || expQ.size() != 0) begin
            nMismatched++;
            $display("FAIL roundtrip_count d=%0d got %0d received %0d pending want %0d received 0 pending",
                     d, received, expQ.size(), n);
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; inValid[d] = 1'b0; inData[d] = 128'h0; outReady[d] = 1'b0;
        end
        test_reset();
        for (int d = 0; d < ND; d++) test_vectors(d);
        for (int d = 0; d < ND; d++) test_backpressure(d);
        test_reset_midop(0);
        test_reset_midop(1);
        test_back_to_back(0, 1000);
        test_back_to_back(1, 200);
        test_back_to_back(2, 200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
